enemy_bullet: RTL and testbench

Generates and tracks the single enemy (alien) bullet that falls toward the player ship, and produces the one-cycle hit strobe that drives the player block's `hit_i`. It sits directly upstream of the player block. It consumes the player's horizontal extent (`pos_left_o`/`pos_right_o`) and the frame strobe. It outputs a bullet box for the VGA renderer in the same left/right/top/bot format the player bullet uses.

---
 rtl/enemy_bullet.sv | 127 ++++++++++++
 tb/tb_enemy_bullet.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/enemy_bullet.sv
// Single falling alien bullet: spawns at a pseudo-random column after a frame delay,
// falls one step per frame and strobes hit_o when it overlaps the player ship.
module enemy_bullet #(
    parameter logic [7:0] spawn_delay_p = 8'd60,
    parameter logic [9:0] step_p        = 10'd4,
    parameter logic [9:0] spawn_top_p   = 10'd40,
    parameter logic [9:0] bottom_p      = 10'd480,
    parameter logic [9:0] player_top_p  = 10'd394,
    parameter logic [9:0] player_bot_p  = 10'd414
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic       frame_i,
    input  logic       enable_i,
    input  logic       clear_i,
    input  logic [9:0] player_left_i,
    input  logic [9:0] player_right_i,
    output logic       hit_o,
    output logic       bullet_o,
    output logic [9:0] bullet_left_o,
    output logic [9:0] bullet_right_o,
    output logic [9:0] bullet_top_o,
    output logic [9:0] bullet_bot_o,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        StIdle = 2'b01,
        StFall = 2'b10
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] delay_q, delay_d;
    logic [9:0] left_q, left_d;
    logic [9:0] top_q, top_d;
    logic       hit_q, hit_d;
    logic [9:0] lfsr_q, lfsr_d;

    logic       tick;
    logic       overlap;
    logic [9:0] spawn_col;
    logic [9:0] top_step;

    // x^10 + x^7 + 1; free-running so spawn columns differ between games.
    assign lfsr_d    = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
    assign spawn_col = 10'd9 + {1'b0, lfsr_q[8:0]} + (lfsr_q[9] ? 10'd100 : 10'd0);

    assign tick     = frame_i & enable_i;
    assign top_step = top_q + step_p;

    assign bullet_left_o  = left_q;
    assign bullet_right_o = left_q + 10'd6;
    assign bullet_top_o   = top_q;
    assign bullet_bot_o   = top_q + 10'd10;
    assign bullet_o       = (state_q == StFall);
    assign hit_o          = hit_q;
    assign state_o        = state_q;

    assign overlap = (bullet_right_o > player_left_i) && (bullet_left_o < player_right_i) &&
                     (bullet_bot_o > player_top_p) && (bullet_top_o < player_bot_p);

    always_comb begin
        state_d = state_q;
        delay_d = delay_q;
        left_d  = left_q;
        top_d   = top_q;
        hit_d   = 1'b0;
        if (clear_i) begin
            state_d = StIdle;
            delay_d = spawn_delay_p;
            top_d   = spawn_top_p;
        end else begin
            case (state_q)
                StIdle: begin
                    if (tick) begin
                        if (delay_q != 8'd0) begin
                            delay_d = delay_q - 8'd1;
                        end else begin
                            left_d  = spawn_col;
                            top_d   = spawn_top_p;
                            state_d = StFall;
                        end
                    end
                end
                StFall: begin
                    if (tick) begin
                        // Hit is tested first so it wins over reaching the bottom.
                        if (overlap) begin
                            hit_d   = 1'b1;
                            state_d = StIdle;
                            delay_d = spawn_delay_p;
                        end else if (top_step >= bottom_p) begin
                            state_d = StIdle;
                            delay_d = spawn_delay_p;
                        end else begin
                            top_d = top_step;
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                    delay_d = spawn_delay_p;
                    top_d   = spawn_top_p;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= StIdle;
            delay_q <= spawn_delay_p;
            left_q  <= 10'd0;
            top_q   <= spawn_top_p;
            hit_q   <= 1'b0;
            lfsr_q  <= 10'h001;
        end else begin
            state_q <= state_d;
            delay_q <= delay_d;
            left_q  <= left_d;
            top_q   <= top_d;
            hit_q   <= hit_d;
            lfsr_q  <= lfsr_d;
        end
    end

endmodule

// File: tb/tb_enemy_bullet.sv
// Directed bench for enemy_bullet: scoreboard of expected outputs, checked after each step.
module tb_enemy_bullet;

    logic       clk_i = 1'b0;
    logic       reset_n_i = 1'b1;
    logic       frame_i = 1'b0;
    logic       enable_i = 1'b1;
    logic       clear_i = 1'b0;
    logic [9:0] player_left_i = 10'd9;
    logic [9:0] player_right_i = 10'd629;
    logic       hit_o;
    logic       bullet_o;
    logic [9:0] bullet_left_o;
    logic [9:0] bullet_right_o;
    logic [9:0] bullet_top_o;
    logic [9:0] bullet_bot_o;
    logic [1:0] state_o;

    always #5 clk_i = ~clk_i;

    enemy_bullet #(
        .spawn_delay_p(8'd2)
    ) dut (
        .clk_i         (clk_i),
        .reset_n_i     (reset_n_i),
        .frame_i       (frame_i),
        .enable_i      (enable_i),
        .clear_i       (clear_i),
        .player_left_i (player_left_i),
        .player_right_i(player_right_i),
        .hit_o         (hit_o),
        .bullet_o      (bullet_o),
        .bullet_left_o (bullet_left_o),
        .bullet_right_o(bullet_right_o),
        .bullet_top_o  (bullet_top_o),
        .bullet_bot_o  (bullet_bot_o),
        .state_o       (state_o)
    );

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned hit_pulses = 0;
    logic [9:0]  m_lfsr;
    logic [31:0] exp_col = 0;

    // Reference LFSR, x^10 + x^7 + 1, seeded by reset.
    always @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) m_lfsr <= 10'h001;
        else            m_lfsr <= {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
    end

    always @(negedge clk_i) begin
        if (hit_o === 1'b1) hit_pulses <= hit_pulses + 1;
    end

    function automatic logic [31:0] col_of(input logic [9:0] l);
        return 32'd9 + {23'd0, l[8:0]} + (l[9] ? 32'd100 : 32'd0);
    endfunction

    task automatic push(input string t, input logic [31:0] v);
        exp_t e;
        e.tag = t;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        n_cmp++;
        assert (sb.size() != 0) else begin
            n_bad++;
            $error("FAIL scoreboard_empty observed=%0d expected=none", obs);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_bad++;
                $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic push3(input logic b, input logic h, input logic [1:0] s);
        push("bullet_o", {31'd0, b});
        push("hit_o", {31'd0, h});
        push("state_o", {30'd0, s});
    endtask

    task automatic chk3();
        check({31'd0, bullet_o});
        check({31'd0, hit_o});
        check({30'd0, state_o});
    endtask

    // One-cycle frame strobe; returns at the negedge after the qualifying posedge.
    task automatic frame();
        @(negedge clk_i);
        frame_i = 1'b1;
        exp_col = col_of(m_lfsr);
        @(negedge clk_i);
        frame_i = 1'b0;
    endtask

    task automatic spawn(input string tag);
        push3(1'b0, 1'b0, 2'b01); frame(); chk3();
        push3(1'b0, 1'b0, 2'b01); frame(); chk3();
        frame();
        push3(1'b1, 1'b0, 2'b10);
        push({tag, "_left"}, exp_col);
        push({tag, "_right"}, exp_col + 6);
        push({tag, "_top"}, 32'd40);
        push({tag, "_left_range"}, 32'd1);
        chk3();
        check({22'd0, bullet_left_o});
        check({22'd0, bullet_right_o});
        check({22'd0, bullet_top_o});
        check({31'd0, (bullet_left_o >= 10'd9) && (bullet_left_o <= 10'd620)});
    endtask

    initial begin
        // Async reset with no clock edge in between.
        #1 reset_n_i = 1'b0;
        #1;
        push3(1'b0, 1'b0, 2'b01);
        push("rst_top", 32'd40);
        push("rst_left", 32'd0);
        push("rst_right", 32'd6);
        push("rst_bot", 32'd50);
        chk3();
        check({22'd0, bullet_top_o});
        check({22'd0, bullet_left_o});
        check({22'd0, bullet_right_o});
        check({22'd0, bullet_bot_o});
        repeat (3) @(negedge clk_i);
        reset_n_i = 1'b1;

        // Guaranteed hit: ship spans the whole playfield.
        spawn("spawn1");
        push("spawn1_bot", 32'd50);
        check({22'd0, bullet_bot_o});
        for (int k = 1; k <= 87; k++) begin
            push("hit_run_top", 32'd40 + 32'd4 * k);
            push("hit_run_hit", 32'd0);
            frame();
            check({22'd0, bullet_top_o});
            check({31'd0, hit_o});
        end
        push3(1'b0, 1'b1, 2'b01);
        frame();
        chk3();
        push("hit_one_cycle", 32'd0);
        @(negedge clk_i);
        check({31'd0, hit_o});

        // Guaranteed miss, with a freeze at top 100.
        player_left_i  = 10'd0;
        player_right_i = 10'd0;
        spawn("spawn2");
        repeat (15) frame();
        push("pre_freeze_top", 32'd100);
        check({22'd0, bullet_top_o});
        enable_i = 1'b0;
        repeat (20) frame();
        push("freeze_top", 32'd100);
        push3(1'b1, 1'b0, 2'b10);
        check({22'd0, bullet_top_o});
        chk3();
        enable_i = 1'b1;
        push("unfreeze_top", 32'd104);
        frame();
        check({22'd0, bullet_top_o});
        repeat (109 - 16) frame();
        push("miss_last_top", 32'd476);
        check({22'd0, bullet_top_o});
        push3(1'b0, 1'b0, 2'b01);
        frame();
        chk3();

        // Clear mid-flight at top 200.
        spawn("spawn3");
        repeat (40) frame();
        push("pre_clear_top", 32'd200);
        check({22'd0, bullet_top_o});
        @(negedge clk_i);
        clear_i = 1'b1;
        @(negedge clk_i);
        clear_i = 1'b0;
        push3(1'b0, 1'b0, 2'b01);
        push("clear_top", 32'd40);
        chk3();
        check({22'd0, bullet_top_o});
        spawn("spawn4");

        // Async reset while the bullet overlaps the ship.
        player_left_i  = 10'd9;
        player_right_i = 10'd629;
        repeat (87) frame();
        push("pre_reset_top", 32'd388);
        check({22'd0, bullet_top_o});
        @(posedge clk_i);
        #2 reset_n_i = 1'b0;
        #1;
        push3(1'b0, 1'b0, 2'b01);
        push("async_top", 32'd40);
        push("async_left", 32'd0);
        chk3();
        check({22'd0, bullet_top_o});
        check({22'd0, bullet_left_o});
        @(negedge clk_i);
        frame_i = 1'b1;
        repeat (2) @(negedge clk_i);
        frame_i = 1'b0;
        reset_n_i = 1'b1;
        repeat (3) @(negedge clk_i);
        push("total_hit_pulses", 32'd1);
        check(hit_pulses);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
